// File: rtl/ysyx_23060236_trap_pkg.sv
// rtl/ysyx_23060236_trap_pkg.sv - shared encodings for the commit-stage trap controller
package ysyx_23060236_trap_pkg;

    localparam int          XLEN          = 32;
    localparam logic [11:0] SATP_ADDR     = 12'h180;
    localparam logic [6:0]  CAUSE_MTIMER  = 7'h47;
    localparam logic [6:0]  CAUSE_ECALL_M = 7'd11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_TRAP  = 3'd2,
        ST_TLBF  = 3'd3,
        ST_REDIR = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        EV_PLAIN = 3'd0,
        EV_IRQ   = 3'd1,
        EV_ECALL = 3'd2,
        EV_MRET  = 3'd3,
        EV_SATPW = 3'd4
    } event_e;

    // Priority order matters: a pending enabled interrupt squashes whatever is committing.
    function automatic event_e classify(
        input logic        irq,
        input logic        ecall,
        input logic        mret,
        input logic        csr_we,
        input logic [11:0] csr_addr,
        input logic [11:0] satp_addr
    );
        if (irq)                                  return EV_IRQ;
        else if (ecall)                           return EV_ECALL;
        else if (mret)                            return EV_MRET;
        else if (csr_we && csr_addr == satp_addr) return EV_SATPW;
        else                                      return EV_PLAIN;
    endfunction

endpackage

// File: rtl/ysyx_23060236_trap_perf.sv
// rtl/ysyx_23060236_trap_perf.sv - trap and interrupt event counters
module ysyx_23060236_trap_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        perf_clr,
    input  logic        trap,
    input  logic        intr,
    output logic [31:0] perf_trap_cnt,
    output logic [31:0] perf_intr_cnt
);

    logic [31:0] trap_cnt_q, trap_cnt_d;
    logic [31:0] intr_cnt_q, intr_cnt_d;

    always_comb begin
        trap_cnt_d = trap_cnt_q;
        intr_cnt_d = intr_cnt_q;
        if (perf_clr) begin
            trap_cnt_d = '0;
            intr_cnt_d = '0;
        end else begin
            if (trap)         trap_cnt_d = trap_cnt_q + 32'd1;
            if (trap && intr) intr_cnt_d = intr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trap_cnt_q <= '0;
            intr_cnt_q <= '0;
        end else begin
            trap_cnt_q <= trap_cnt_d;
            intr_cnt_q <= intr_cnt_d;
        end
    end

    assign perf_trap_cnt = trap_cnt_q;
    assign perf_intr_cnt = intr_cnt_q;

endmodule

// File: rtl/ysyx_23060236_trap_ctrl.sv
// rtl/ysyx_23060236_trap_ctrl.sv - commit sequencer: CSR strobe, trap/mret/satp redirects
// Optional counters enabled by YSYX_23060236_TRAP_PERF_EN.
module ysyx_23060236_trap_ctrl #(
    parameter int          XLEN      = 32,
    parameter logic [11:0] SATP_ADDR = ysyx_23060236_trap_pkg::SATP_ADDR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmt_valid,
    output logic            cmt_ready,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic            cmt_ecall,
    input  logic            cmt_mret,
    input  logic            cmt_csr_we,
    input  logic [11:0]     cmt_csr_addr,
    input  logic            time_intr,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            mem_idle,
    output logic            csr_valid,
    output logic            csr_intr,
    output logic [XLEN-1:0] csr_epc,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            tlb_flush_req,
    input  logic            tlb_flush_ack
`ifdef YSYX_23060236_TRAP_PERF_EN
    ,
    input  logic            perf_clr,
    output logic [31:0]     perf_trap_cnt,
    output logic [31:0]     perf_intr_cnt
`endif
);

    import ysyx_23060236_trap_pkg::*;

    state_e          state_q, state_d;
    event_e          class_q, class_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;

    logic   accept;
    logic   in_trap;
    event_e ev;

    assign ev = classify(time_intr & mstatus_mie, cmt_ecall, cmt_mret,
                         cmt_csr_we, cmt_csr_addr, SATP_ADDR);

    assign cmt_ready = (state_q == ST_IDLE);
    assign accept    = cmt_valid & cmt_ready;
    assign in_trap   = (state_q == ST_TRAP);

    always_comb begin
        state_d  = state_q;
        class_d  = class_q;
        pc_d     = pc_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    class_d = ev;
                    pc_d    = cmt_pc;
                    case (ev)
                        EV_IRQ, EV_ECALL, EV_MRET: state_d = mem_idle ? ST_TRAP : ST_DRAIN;
                        EV_SATPW:                  state_d = ST_TLBF;
                        default:                   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_DRAIN: begin
                if (mem_idle) state_d = ST_TRAP;
            end
            ST_TRAP: begin
                // Vectors are sampled here, before the CSR update lands.
                target_d = (class_q == EV_MRET) ? mepc : mtvec;
                state_d  = ST_REDIR;
            end
            ST_TLBF: begin
                if (tlb_flush_ack) begin
                    target_d = pc_q + XLEN'(4);
                    state_d  = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (redir_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            class_q  <= EV_PLAIN;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    assign csr_valid     = (accept & ((ev == EV_PLAIN) | (ev == EV_SATPW))) | in_trap;
    assign csr_intr      = in_trap & (class_q == EV_IRQ);
    assign csr_epc       = in_trap ? pc_q : cmt_pc;
    assign redir_valid   = (state_q == ST_REDIR);
    assign flush         = (state_q == ST_REDIR);
    assign redir_pc      = target_q;
    assign tlb_flush_req = (state_q == ST_TLBF);

`ifdef YSYX_23060236_TRAP_PERF_EN
    ysyx_23060236_trap_perf u_perf (
        .clock         (clock),
        .reset         (reset),
        .perf_clr      (perf_clr),
        .trap          (in_trap),
        .intr          (csr_intr),
        .perf_trap_cnt (perf_trap_cnt),
        .perf_intr_cnt (perf_intr_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_23060236_trap_ctrl.sv
// tb/tb_ysyx_23060236_trap_ctrl.sv - self-checking bench for the trap controller
module tb_ysyx_23060236_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmt_valid, cmt_ecall, cmt_mret, cmt_csr_we;
    logic [31:0] cmt_pc, mtvec, mepc;
    logic [11:0] cmt_csr_addr;
    logic        time_intr, mstatus_mie, mem_idle, redir_ready, tlb_flush_ack;
    logic        cmt_ready, csr_valid, csr_intr, redir_valid, flush, tlb_flush_req;
    logic [31:0] csr_epc, redir_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ysyx_23060236_trap_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .cmt_valid     (cmt_valid),
        .cmt_ready     (cmt_ready),
        .cmt_pc        (cmt_pc),
        .cmt_ecall     (cmt_ecall),
        .cmt_mret      (cmt_mret),
        .cmt_csr_we    (cmt_csr_we),
        .cmt_csr_addr  (cmt_csr_addr),
        .time_intr     (time_intr),
        .mstatus_mie   (mstatus_mie),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .mem_idle      (mem_idle),
        .csr_valid     (csr_valid),
        .csr_intr      (csr_intr),
        .csr_epc       (csr_epc),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flush         (flush),
        .tlb_flush_req (tlb_flush_req),
        .tlb_flush_ack (tlb_flush_ack)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: a pending "sequence" described by what is still owed to the outside.
    localparam int K_PLAIN = 0, K_IRQ = 1, K_ECALL = 2, K_MRET = 3, K_SATP = 4;
    bit          busy, owe_drain, owe_strobe, owe_tlb, owe_redir;
    int          m_kind;
    logic [31:0] m_pc, m_tgt;
    int          k;
    bit          acc;

    function automatic int kind_of();
        if (time_intr && mstatus_mie)                return K_IRQ;
        if (cmt_ecall)                               return K_ECALL;
        if (cmt_mret)                                return K_MRET;
        if (cmt_csr_we && cmt_csr_addr == 12'h180)   return K_SATP;
        return K_PLAIN;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            busy = 0; owe_drain = 0; owe_strobe = 0; owe_tlb = 0; owe_redir = 0;
            chk("m_rst_ready", 32'(cmt_ready), 32'd1);
            chk("m_rst_csr_valid", 32'(csr_valid), 32'd0);
            chk("m_rst_redir_valid", 32'(redir_valid), 32'd0);
            chk("m_rst_tlb_req", 32'(tlb_flush_req), 32'd0);
        end else begin
            k   = kind_of();
            acc = !busy && cmt_valid;
            chk("m_cmt_ready", 32'(cmt_ready), 32'(!busy));
            chk("m_csr_valid", 32'(csr_valid), 32'((acc && (k == K_PLAIN || k == K_SATP)) || owe_strobe));
            chk("m_csr_intr", 32'(csr_intr), 32'(owe_strobe && m_kind == K_IRQ));
            if (owe_strobe) chk("m_csr_epc", csr_epc, m_pc);
            chk("m_redir_valid", 32'(redir_valid), 32'(owe_redir));
            chk("m_flush", 32'(flush), 32'(owe_redir));
            if (owe_redir) chk("m_redir_pc", redir_pc, m_tgt);
            chk("m_tlb_req", 32'(tlb_flush_req), 32'(owe_tlb));
            if (acc) begin
                if (k != K_PLAIN) begin
                    busy = 1; m_kind = k; m_pc = cmt_pc;
                    if (k == K_SATP)   owe_tlb = 1;
                    else if (mem_idle) owe_strobe = 1;
                    else               owe_drain = 1;
                end
            end else if (owe_drain) begin
                if (mem_idle) begin owe_drain = 0; owe_strobe = 1; end
            end else if (owe_strobe) begin
                owe_strobe = 0; owe_redir = 1;
                m_tgt = (m_kind == K_MRET) ? mepc : mtvec;
            end else if (owe_tlb) begin
                if (tlb_flush_ack) begin owe_tlb = 0; owe_redir = 1; m_tgt = m_pc + 32'd4; end
            end else if (owe_redir && redir_ready) begin
                owe_redir = 0; busy = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cmt_valid = 0; cmt_ecall = 0; cmt_mret = 0; cmt_csr_we = 0; cmt_csr_addr = 12'h300;
        time_intr = 0; mstatus_mie = 0; mem_idle = 1; redir_ready = 1; tlb_flush_ack = 0;
    endtask

    initial begin
        reset = 1;
        cmt_pc = 32'h80000000; mtvec = 32'h80001000; mepc = 32'h80000200;
        idle_inputs();
        repeat (3) cyc();
        reset = 0;
        settle();
        chk("reset_ready", 32'(cmt_ready), 32'd1);
        chk("reset_csr_valid", 32'(csr_valid), 32'd0);
        chk("reset_redir_valid", 32'(redir_valid), 32'd0);
        cyc();

        // plain stream
        for (int i = 0; i < 4; i++) begin
            cmt_valid = 1; cmt_pc = 32'h80000000 + 32'(i * 4);
            settle();
            chk("plain_csr_valid", 32'(csr_valid), 32'd1);
            chk("plain_ready", 32'(cmt_ready), 32'd1);
            chk("plain_redir", 32'(redir_valid), 32'd0);
            cyc();
        end
        idle_inputs();
        cyc();

        // ecall with three drain cycles
        cmt_valid = 1; cmt_ecall = 1; cmt_pc = 32'h80000010; mtvec = 32'h80001000; mem_idle = 0;
        settle();
        chk("ecall_accept_csr_valid", 32'(csr_valid), 32'd0);
        cyc(); cmt_valid = 0; cmt_ecall = 0;
        settle(); chk("ecall_drain1", 32'(cmt_ready), 32'd0);
        cyc(); settle(); chk("ecall_drain2", 32'(csr_valid), 32'd0);
        cyc(); mem_idle = 1; settle(); chk("ecall_drain3", 32'(csr_valid), 32'd0);
        cyc(); settle();
        chk("ecall_trap_valid", 32'(csr_valid), 32'd1);
        chk("ecall_trap_epc", csr_epc, 32'h80000010);
        chk("ecall_trap_intr", 32'(csr_intr), 32'd0);
        cyc(); settle();
        chk("ecall_redir_valid", 32'(redir_valid), 32'd1);
        chk("ecall_redir_pc", redir_pc, 32'h80001000);
        chk("ecall_flush", 32'(flush), 32'd1);
        cyc(); settle();
        chk("ecall_back_idle", 32'(cmt_ready), 32'd1);
        cyc();

        // interrupt beats ecall, time_intr drops during drain
        cmt_valid = 1; cmt_ecall = 1; time_intr = 1; mstatus_mie = 1; mem_idle = 0;
        cmt_pc = 32'h80000040; mtvec = 32'h80002000;
        cyc(); cmt_valid = 0; cmt_ecall = 0; time_intr = 0; mem_idle = 1;
        cyc(); settle();
        chk("irq_trap_intr", 32'(csr_intr), 32'd1);
        chk("irq_trap_epc", csr_epc, 32'h80000040);
        cyc(); settle();
        chk("irq_redir_pc", redir_pc, 32'h80002000);
        cyc(); idle_inputs(); cyc();

        // mret with a stalled redirect
        cmt_valid = 1; cmt_mret = 1; mepc = 32'h80000200; mem_idle = 1; redir_ready = 0;
        cyc(); cmt_valid = 0; cmt_mret = 0;
        settle(); chk("mret_trap_valid", 32'(csr_valid), 32'd1);
        cyc();
        for (int i = 0; i < 6; i++) begin
            redir_ready = (i == 5);
            settle();
            chk("mret_redir_valid", 32'(redir_valid), 32'd1);
            chk("mret_redir_pc", redir_pc, 32'h80000200);
            chk("mret_flush", 32'(flush), 32'd1);
            cyc();
        end
        chk("mret_back_idle", 32'(cmt_ready), 32'd1);
        chk("mret_redir_done", 32'(redir_valid), 32'd0);
        idle_inputs(); cyc();

        // satp write, ack in the fourth TLBF cycle
        cmt_valid = 1; cmt_csr_we = 1; cmt_csr_addr = 12'h180; cmt_pc = 32'h80000FFC;
        settle(); chk("satp_accept_strobe", 32'(csr_valid), 32'd1);
        cyc(); cmt_valid = 0; cmt_csr_we = 0;
        for (int i = 0; i < 4; i++) begin
            tlb_flush_ack = (i == 3);
            settle(); chk("satp_tlb_req", 32'(tlb_flush_req), 32'd1);
            cyc();
        end
        tlb_flush_ack = 0;
        settle();
        chk("satp_redir_pc", redir_pc, 32'h80001000);
        chk("satp_redir_valid", 32'(redir_valid), 32'd1);
        cyc(); cyc();

        // satp at the top of the address space wraps to 0
        cmt_valid = 1; cmt_csr_we = 1; cmt_csr_addr = 12'h180; cmt_pc = 32'hFFFFFFFC;
        cyc(); cmt_valid = 0; cmt_csr_we = 0; tlb_flush_ack = 1;
        settle(); chk("wrap_tlb_req", 32'(tlb_flush_req), 32'd1);
        cyc(); tlb_flush_ack = 0;
        settle(); chk("wrap_redir_pc", redir_pc, 32'h00000000);
        cyc(); cyc();

        // reset while in TLBF
        cmt_valid = 1; cmt_csr_we = 1; cmt_csr_addr = 12'h180; cmt_pc = 32'h80003000;
        cyc(); cmt_valid = 0; cmt_csr_we = 0;
        cyc(); reset = 1;
        settle();
        chk("rst_tlbf_req", 32'(tlb_flush_req), 32'd0);
        chk("rst_tlbf_ready", 32'(cmt_ready), 32'd1);
        cyc(); reset = 0; tlb_flush_ack = 1;
        cyc(); settle();
        chk("rst_tlbf_no_redir", 32'(redir_valid), 32'd0);
        tlb_flush_ack = 0; cyc();

        // reset while in REDIR
        cmt_valid = 1; cmt_mret = 1; redir_ready = 0;
        cyc(); cmt_valid = 0; cmt_mret = 0;
        cyc(); cyc(); reset = 1;
        settle();
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_redir_flush", 32'(flush), 32'd0);
        cyc(); reset = 0; redir_ready = 1;
        cyc(); settle();
        chk("rst_redir_stale", 32'(redir_valid), 32'd0);
        chk("rst_redir_ready", 32'(cmt_ready), 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            cyc();
            reset = ($urandom_range(0, 299) == 0);
            sel = int'($urandom_range(0, 7));
            cmt_valid     = !reset && ($urandom_range(0, 9) < 6);
            cmt_ecall     = (sel == 0);
            cmt_mret      = (sel == 1);
            cmt_csr_we    = (sel == 2 || sel == 3);
            cmt_csr_addr  = (sel == 2) ? 12'h180 : 12'($urandom);
            cmt_pc        = $urandom & 32'hFFFFFFFC;
            mtvec         = $urandom & 32'hFFFFFFFC;
            mepc          = $urandom & 32'hFFFFFFFC;
            time_intr     = ($urandom_range(0, 7) == 0);
            mstatus_mie   = 1'($urandom);
            mem_idle      = 1'($urandom);
            redir_ready   = ($urandom_range(0, 2) != 0);
            tlb_flush_ack = ($urandom_range(0, 2) == 0);
        end
        cyc(); reset = 0; idle_inputs();
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
